// File: rtl/hazard_halt_controller.sv
// Hazard/halt controller for a 5-stage pipeline: load/RAW stalls, branch flush, HALT drain.
// Optional macro HAZARD_FORWARD_EN: forwarding present, only load-use hazards stall.
module hazard_halt_controller #(
    parameter int RegAddrBits = 3,
    parameter int DrainCycles = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [RegAddrBits-1:0] id_rs,
    input  logic [RegAddrBits-1:0] id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic [RegAddrBits-1:0] ex_rd,
    input  logic                   ex_wen,
    input  logic                   ex_memread,
    input  logic [RegAddrBits-1:0] mem_rd,
    input  logic                   mem_wen,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   halted,
    output logic [7:0]             stall_count
);

    localparam int CntW = (DrainCycles > 2) ? $clog2(DrainCycles) : 1;
    localparam logic [CntW-1:0] DrainInit = CntW'(DrainCycles - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [CntW-1:0] r_drain_cnt;
    logic [7:0]      r_stall_count;

    logic w_match_ex;
    logic w_hazard;
    logic w_stall;
    logic w_halt_go;

    // $0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic f_match(input logic uses,
                                     input logic [RegAddrBits-1:0] src,
                                     input logic [RegAddrBits-1:0] dest,
                                     input logic wen);
        return uses && (src == dest) && (dest != '0) && wen;
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    assign w_match_ex = f_match(id_uses_rs, id_rs, ex_rd, ex_wen) ||
                        f_match(id_uses_rt, id_rt, ex_rd, ex_wen);

`ifdef HAZARD_FORWARD_EN
    logic w_unused_mem;
    assign w_unused_mem = ^{mem_rd, mem_wen};
    assign w_hazard     = ex_memread && w_match_ex;
`else
    logic w_unused_memread;
    assign w_unused_memread = ex_memread;
    assign w_hazard = w_match_ex ||
                      f_match(id_uses_rs, id_rs, mem_rd, mem_wen) ||
                      f_match(id_uses_rt, id_rt, mem_rd, mem_wen);
`endif

    // A taken branch squashes whatever sits in ID, so its hazard or HALT is moot.
    assign w_stall   = (r_state == RUN) && !branch_taken && w_hazard;
    assign w_halt_go = (r_state == RUN) && !branch_taken && !w_hazard && id_halt;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        case (r_state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_halt) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        endcase
        if (RST) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= RUN;
            r_drain_cnt   <= '0;
            r_stall_count <= 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_stall) begin
                        r_stall_count <= f_sat_inc(r_stall_count);
                    end else if (w_halt_go) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= DrainInit;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_halt_controller.sv
// Table-driven bench for hazard_halt_controller; expected outputs queued per driven cycle.
module tb_hazard_halt_controller;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rs, id_uses_rt, id_halt, ex_wen, ex_memread, mem_wen, branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, halted;
    logic [7:0] stall_count;

    always #5 CLK = ~CLK;

    hazard_halt_controller #(.RegAddrBits(3), .DrainCycles(3)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .halted(halted), .stall_count(stall_count)
    );

    typedef struct {
        logic       rst, br, halt, urs, urt, exwen, exmr, memwen;
        logic [2:0] rs, rt, exrd, memrd;
        logic [3:0] exp4;   // {pc_write, ifid_write, ifid_flush, idex_bubble}
        logic       ehalt;
        logic [7:0] esc;
        int         tag;
    } vec_t;

    localparam logic [3:0] O_RUN = 4'b1100, O_STALL = 4'b0001, O_BR = 4'b1111,
                           O_RST = 4'b0011, O_PASS = 4'b0000;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input logic rst, br, halt, urs, input logic [2:0] rs,
                               input logic urt, input logic [2:0] rt, input logic [2:0] exrd,
                               input logic exwen, exmr, input logic [2:0] memrd,
                               input logic memwen, input logic [3:0] exp4,
                               input logic ehalt, input logic [7:0] esc, input int tag);
        vec_t t;
        t.rst = rst; t.br = br; t.halt = halt; t.urs = urs; t.rs = rs; t.urt = urt; t.rt = rt;
        t.exrd = exrd; t.exwen = exwen; t.exmr = exmr; t.memrd = memrd; t.memwen = memwen;
        t.exp4 = exp4; t.ehalt = ehalt; t.esc = esc; t.tag = tag;
        return t;
    endfunction

    function automatic vec_t quiet(input logic rst, input logic [3:0] e, input logic eh,
                                   input logic [7:0] sc, input int tag);
        return v(rst, 0, 0, 0, 3'd0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 0, e, eh, sc, tag);
    endfunction

    // Load to $2 in EX read by ID via rt: stalls in both configurations.
    function automatic vec_t loaduse(input logic halt, br, input logic [3:0] e,
                                     input logic eh, input logic [7:0] sc, input int tag);
        return v(0, br, halt, 0, 3'd0, 1, 3'd2, 3'd2, 1, 1, 3'd0, 0, e, eh, sc, tag);
    endfunction

    task automatic cmp(input string name, input int tag, input logic [7:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            cmp("pc_write",    e.tag, {7'd0, pc_write},    {7'd0, e.exp4[3]});
            cmp("ifid_write",  e.tag, {7'd0, ifid_write},  {7'd0, e.exp4[2]});
            cmp("ifid_flush",  e.tag, {7'd0, ifid_flush},  {7'd0, e.exp4[1]});
            cmp("idex_bubble", e.tag, {7'd0, idex_bubble}, {7'd0, e.exp4[0]});
            cmp("halted",      e.tag, {7'd0, halted},      {7'd0, e.ehalt});
            cmp("stall_count", e.tag, stall_count,         e.esc);
        end
    endtask

    task automatic step(input vec_t t);
        RST = t.rst; branch_taken = t.br; id_halt = t.halt;
        id_uses_rs = t.urs; id_rs = t.rs; id_uses_rt = t.urt; id_rt = t.rt;
        ex_rd = t.exrd; ex_wen = t.exwen; ex_memread = t.exmr;
        mem_rd = t.memrd; mem_wen = t.memwen;
        sb.push_back(t);
        @(negedge CLK);
        check_out();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] sc1, sc2, sc3, sc4;
        logic [3:0] raw_ex, raw_mem;
        raw_ex  = FWD ? O_RUN : O_STALL;
        raw_mem = FWD ? O_RUN : O_STALL;
        sc1 = FWD ? 8'd0 : 8'd1;
        sc2 = sc1 + 8'd1;
        sc3 = FWD ? sc2 : sc2 + 8'd1;
        sc4 = sc3 + 8'd1;

        tbl.push_back(quiet(1, O_RST, 0, 8'd0, 0));
        tbl.push_back(quiet(0, O_RUN, 0, 8'd0, 1));
        // ID reads $4, ALU result to $4 in EX
        tbl.push_back(v(0, 0, 0, 1, 3'd4, 0, 3'd0, 3'd4, 1, 0, 3'd0, 0, raw_ex, 0, 8'd0, 2));
        tbl.push_back(quiet(0, O_RUN, 0, sc1, 3));
        // load to $5 in EX, ID reads $5 via rt
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 1, 3'd5, 3'd5, 1, 1, 3'd0, 0, O_STALL, 0, sc1, 4));
        tbl.push_back(quiet(0, O_RUN, 0, sc2, 5));
        tbl.push_back(v(0, 0, 0, 1, 3'd0, 0, 3'd0, 3'd0, 1, 1, 3'd0, 0, O_RUN, 0, sc2, 6));
        tbl.push_back(v(0, 0, 0, 0, 3'd0, 1, 3'd3, 3'd0, 0, 0, 3'd3, 1, raw_mem, 0, sc2, 7));
        tbl.push_back(v(0, 0, 0, 1, 3'd6, 0, 3'd0, 3'd6, 0, 1, 3'd0, 0, O_RUN, 0, sc3, 8));
        tbl.push_back(v(0, 0, 0, 0, 3'd6, 0, 3'd6, 3'd6, 1, 1, 3'd6, 1, O_RUN, 0, sc3, 9));
        tbl.push_back(loaduse(1, 1, O_BR, 0, sc3, 10));
        tbl.push_back(quiet(0, O_RUN, 0, sc3, 11));
        tbl.push_back(loaduse(1, 0, O_STALL, 0, sc3, 12));
        tbl.push_back(quiet(0, O_RUN, 0, sc4, 13));
        tbl.push_back(v(0, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 0, O_PASS, 0, sc4, 14));
        tbl.push_back(loaduse(1, 1, O_STALL, 0, sc4, 15));
        tbl.push_back(quiet(0, O_STALL, 0, sc4, 16));
        tbl.push_back(quiet(0, O_STALL, 0, sc4, 17));
        tbl.push_back(quiet(0, O_STALL, 1, sc4, 18));
        tbl.push_back(loaduse(1, 0, O_STALL, 1, sc4, 19));
        tbl.push_back(quiet(1, O_RST, 0, sc4, 20));
        tbl.push_back(quiet(0, O_RUN, 0, 8'd0, 21));

        RST = 1'b1; branch_taken = 0; id_halt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; ex_wen = 0; ex_memread = 0; mem_rd = 0; mem_wen = 0;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // reset asserted in the middle of a drain
        step(loaduse(0, 0, O_STALL, 0, 8'd0, 100));
        step(v(0, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 0, O_PASS, 0, 8'd1, 101));
        step(quiet(0, O_STALL, 0, 8'd1, 102));
        step(quiet(1, O_RST, 0, 8'd1, 103));
        step(quiet(0, O_RUN, 0, 8'd0, 104));

        // saturating stall counter
        for (int i = 0; i < 300; i++)
            step(loaduse(0, 0, O_STALL, 0, (i < 255) ? 8'(i) : 8'd255, 200));
        step(quiet(0, O_RUN, 0, 8'd255, 201));

        // full drain then a long halted stretch, left only by reset
        step(v(0, 0, 1, 0, 3'd0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 0, O_PASS, 0, 8'd255, 300));
        for (int i = 0; i < 3; i++) step(quiet(0, O_STALL, 0, 8'd255, 301));
        for (int i = 0; i < 20; i++) step(quiet(0, O_STALL, 1, 8'd255, 302));
        step(quiet(1, O_RST, 0, 8'd255, 303));
        step(quiet(0, O_RUN, 0, 8'd0, 304));

        cmp("scoreboard_drained", 0, 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_halt_controller.md
HAZARD_HALT_CONTROLLER -- requirements
Module: hazard_halt_controller

Interface
REQ-001 SHALL have parameter RegAddrBits, default 3, meaning register-specifier width (8 registers, $0 hardwired zero).
REQ-002 SHALL have parameter DrainCycles, default 3, meaning cycles after HALT leaves ID until the pipeline is empty (EX, MEM, WB).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports id_rs, id_rt  input  RegAddrBits  ID-stage source specifiers.
REQ-006 SHALL have ports id_uses_rs, id_uses_rt  input  1  ID instruction actually reads rs / rt.
REQ-007 SHALL have port id_halt  input  1  HALT decoded in ID.
REQ-008 SHALL have ports ex_rd  input  RegAddrBits, ex_wen  input  1, ex_memread  input  1  EX-stage destination, write enable, load flag.
REQ-009 SHALL have ports mem_rd  input  RegAddrBits, mem_wen  input  1  MEM-stage destination and write enable.
REQ-010 SHALL have port branch_taken  input  1  branch resolved taken in EX.
REQ-011 SHALL have ports pc_write, ifid_write  output  1  enable PC and IF/ID register update.
REQ-012 SHALL have ports ifid_flush, idex_bubble  output  1  clear IF/ID; insert NOP into ID/EX.
REQ-013 SHALL have port halted  output  1  pipeline fully drained after HALT.
REQ-014 SHALL have port stall_count  output  8  saturating count of hazard-stall cycles.

Function
REQ-015 SHALL implement states RUN, DRAIN, HALTED; outputs combinational from state and inputs.
REQ-016 SHALL define match(x) = id_uses_x AND (id_x == dest) AND dest != 0 AND dest write enable set.
REQ-017 SHALL, in RUN, on hazard (REQ-025/026): pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, stall_count+1 (saturate at 255).
REQ-018 SHALL, in RUN, on branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; branch overrides hazard and id_halt; no stall counted.
REQ-019 SHALL, in RUN, with id_halt, no hazard, no branch: pass HALT into EX (idex_bubble=0), pc_write=0, ifid_write=0, go to DRAIN with counter=DrainCycles-1.
REQ-020 SHALL, in RUN, with id_halt and a hazard: stall per REQ-017 and stay in RUN.
REQ-021 SHALL, in DRAIN: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; decrement counter; go to HALTED when counter==0.
REQ-022 SHALL, in DRAIN, ignore branch_taken, hazards and id_halt.
REQ-023 SHALL, in HALTED: halted=1, pc_write=0, ifid_write=0, idex_bubble=1; only RST leaves HALTED.
REQ-024 SHALL, in RUN with no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, halted=0.

Configuration
REQ-025 SHALL, with macro HAZARD_FORWARD_EN defined, declare a hazard only on load-use: ex_memread AND match(rs or rt) against EX; one stall cycle per load.
REQ-026 SHALL, without HAZARD_FORWARD_EN, declare a hazard on match(rs or rt) against EX or MEM destinations, regardless of ex_memread; stall repeats until no match.

Reset
REQ-027 SHALL, on CLK edge with RST=1, set state=RUN, drain counter=0, stall_count=0.
REQ-028 SHALL, while RST=1, drive pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, halted=0.
REQ-029 SHALL, on RST asserted mid-DRAIN or in HALTED, return to RUN on the next edge with stall_count cleared.

Verification
REQ-030 SHALL cover: ID reads $4 (id_uses_rs=1,id_rs=4), EX writes $4 (ex_wen=1,ex_rd=4,ex_memread=0) -> without macro 1 stall, stall_count=1; with macro no stall.
REQ-031 SHALL cover: load to $5 in EX, ID reads $5 via rt -> exactly one cycle pc_write=0, idex_bubble=1 (both configs); match on ex_rd=0 -> no stall.
REQ-032 SHALL cover: id_halt=1 in RUN, quiet pipe -> DRAIN 3 cycles, halted=1 on 4th cycle, remains 1 for 20 cycles.
REQ-033 SHALL cover: branch_taken=1 with id_halt=1 and hazard -> ifid_flush=1, idex_bubble=1, state RUN, stall_count unchanged.
REQ-034 SHALL cover: 300 consecutive hazard cycles -> stall_count=255; RST in HALTED -> next cycle RUN, halted=0, stall_count=0.
